// File: rtl/eth1_cfg_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : eth1_cfg_target
// Brief    : Ethernet MAC config-register target with settle-delayed writes.
// Revision : 1.0
// ============================================================================
module eth1_cfg_target #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk_hifreq,
    input  logic        rst_n,
    input  logic        wren,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] data_in,
    output logic        busy,
    input  logic        err_clr,
    output logic        err_addr,
    output logic        err_ovr,
    input  logic [7:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [47:0] mac_addr,
    output logic        tx_en,
    output logic        rx_en,
    output logic        promisc,
    output logic        loopback,
    output logic [7:0]  ifg,
    output logic [13:0] mtu,
    output logic        cfg_update
);

    localparam logic [3:0]  C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  C_IFG_RST     = 8'd12;
    localparam logic [13:0] C_MTU_RST     = 14'd1518;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SETTLE  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state_q,       w_state_d;
    logic [3:0]  r_cnt_q,         w_cnt_d;
    logic [7:0]  r_sh_addr_q,     w_sh_addr_d;
    logic [31:0] r_sh_data_q,     w_sh_data_d;
    logic        r_busy_q,        w_busy_d;
    logic        r_cfg_update_q,  w_cfg_update_d;
    logic        r_err_addr_q,    w_err_addr_d;
    logic        r_err_ovr_q,     w_err_ovr_d;
    logic [31:0] r_rd_data_q,     w_rd_data_d;
    logic [31:0] r_mac_lo_q,      w_mac_lo_d;
    logic [15:0] r_mac_hi_q,      w_mac_hi_d;
    logic [3:0]  r_ctrl_q,        w_ctrl_d;
    logic [7:0]  r_ifg_q,         w_ifg_d;
    logic [13:0] r_mtu_q,         w_mtu_d;
    logic [31:0] r_scratch_q,     w_scratch_d;
    logic        w_addr_evt;

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_sh_addr_d = r_sh_addr_q;
        w_sh_data_d = r_sh_data_q;
        w_mac_lo_d  = r_mac_lo_q;
        w_mac_hi_d  = r_mac_hi_q;
        w_ctrl_d    = r_ctrl_q;
        w_ifg_d     = r_ifg_q;
        w_mtu_d     = r_mtu_q;
        w_scratch_d = r_scratch_q;
        w_addr_evt  = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (wren) begin
                    w_sh_addr_d = reg_addr;
                    w_sh_data_d = data_in;
                    w_state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (r_sh_addr_q <= 8'h05) begin
                    w_state_d = S_SETTLE;
                    w_cnt_d   = 4'd0;
                end else begin
                    w_state_d  = S_IDLE;
                    w_addr_evt = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_cnt_q == C_SETTLE_LAST) begin
                    w_state_d = S_DONE;
                    // Live register changes on the same edge that enters DONE.
                    case (r_sh_addr_q)
                        8'h00:   w_mac_lo_d  = r_sh_data_q;
                        8'h01:   w_mac_hi_d  = r_sh_data_q[15:0];
                        8'h02:   w_ctrl_d    = r_sh_data_q[3:0];
                        8'h03:   w_ifg_d     = r_sh_data_q[7:0];
                        8'h04:   w_mtu_d     = r_sh_data_q[13:0];
                        8'h05:   w_scratch_d = r_sh_data_q;
                        default: ;
                    endcase
                end else begin
                    w_cnt_d = r_cnt_q + 4'd1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_busy_d       = (w_state_d != S_IDLE);
        w_cfg_update_d = (w_state_d == S_DONE);

        // A new error event beats a simultaneous clear.
        w_err_addr_d = w_addr_evt | (r_err_addr_q & ~err_clr);
        w_err_ovr_d  = (wren & r_busy_q) | (r_err_ovr_q & ~err_clr);

        case (rd_addr)
            8'h00:   w_rd_data_d = r_mac_lo_q;
            8'h01:   w_rd_data_d = {16'd0, r_mac_hi_q};
            8'h02:   w_rd_data_d = {28'd0, r_ctrl_q};
            8'h03:   w_rd_data_d = {24'd0, r_ifg_q};
            8'h04:   w_rd_data_d = {18'd0, r_mtu_q};
            8'h05:   w_rd_data_d = r_scratch_q;
            default: w_rd_data_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk_hifreq or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q      <= S_IDLE;
            r_cnt_q        <= 4'd0;
            r_sh_addr_q    <= 8'd0;
            r_sh_data_q    <= 32'd0;
            r_busy_q       <= 1'b0;
            r_cfg_update_q <= 1'b0;
            r_err_addr_q   <= 1'b0;
            r_err_ovr_q    <= 1'b0;
            r_rd_data_q    <= 32'd0;
            r_mac_lo_q     <= 32'd0;
            r_mac_hi_q     <= 16'd0;
            r_ctrl_q       <= 4'd0;
            r_ifg_q        <= C_IFG_RST;
            r_mtu_q        <= C_MTU_RST;
            r_scratch_q    <= 32'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_sh_addr_q    <= w_sh_addr_d;
            r_sh_data_q    <= w_sh_data_d;
            r_busy_q       <= w_busy_d;
            r_cfg_update_q <= w_cfg_update_d;
            r_err_addr_q   <= w_err_addr_d;
            r_err_ovr_q    <= w_err_ovr_d;
            r_rd_data_q    <= w_rd_data_d;
            r_mac_lo_q     <= w_mac_lo_d;
            r_mac_hi_q     <= w_mac_hi_d;
            r_ctrl_q       <= w_ctrl_d;
            r_ifg_q        <= w_ifg_d;
            r_mtu_q        <= w_mtu_d;
            r_scratch_q    <= w_scratch_d;
        end
    end

    assign busy       = r_busy_q;
    assign cfg_update = r_cfg_update_q;
    assign err_addr   = r_err_addr_q;
    assign err_ovr    = r_err_ovr_q;
    assign rd_data    = r_rd_data_q;
    assign mac_addr   = {r_mac_hi_q, r_mac_lo_q};
    assign tx_en      = r_ctrl_q[0];
    assign rx_en      = r_ctrl_q[1];
    assign promisc    = r_ctrl_q[2];
    assign loopback   = r_ctrl_q[3];
    assign ifg        = r_ifg_q;
    assign mtu        = r_mtu_q;

endmodule
`default_nettype wire

// File: tb/tb_eth1_cfg_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth1_cfg_target
// Brief    : Self-checking bench for eth1_cfg_target against a register model.
// Revision : 1.0
// ============================================================================
module tb_eth1_cfg_target;

    localparam int SETTLE_CYCLES = 4;

    logic        clk_hifreq;
    logic        rst_n;
    logic        wren;
    logic [7:0]  reg_addr;
    logic [31:0] data_in;
    logic        busy;
    logic        err_clr;
    logic        err_addr;
    logic        err_ovr;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [47:0] mac_addr;
    logic        tx_en, rx_en, promisc, loopback;
    logic [7:0]  ifg;
    logic [13:0] mtu;
    logic        cfg_update;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the architectural register file.
    logic [31:0] m_mac_lo, m_scratch;
    logic [15:0] m_mac_hi;
    logic [3:0]  m_ctrl;
    logic [7:0]  m_ifg;
    logic [13:0] m_mtu;

    eth1_cfg_target #(.SETTLE_CYCLES(SETTLE_CYCLES)) dut (
        .clk_hifreq (clk_hifreq),
        .rst_n      (rst_n),
        .wren       (wren),
        .reg_addr   (reg_addr),
        .data_in    (data_in),
        .busy       (busy),
        .err_clr    (err_clr),
        .err_addr   (err_addr),
        .err_ovr    (err_ovr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .mac_addr   (mac_addr),
        .tx_en      (tx_en),
        .rx_en      (rx_en),
        .promisc    (promisc),
        .loopback   (loopback),
        .ifg        (ifg),
        .mtu        (mtu),
        .cfg_update (cfg_update)
    );

    initial begin
        clk_hifreq = 1'b0;
        forever #5 clk_hifreq = ~clk_hifreq;
    end

    function automatic void model_reset();
        m_mac_lo = 0; m_mac_hi = 0; m_ctrl = 0; m_scratch = 0;
        m_ifg = 8'd12; m_mtu = 14'd1518;
    endfunction

    function automatic bit model_mapped(input logic [7:0] a);
        return a < 8'd6;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d);
        case (a)
            8'h00: m_mac_lo  = d;
            8'h01: m_mac_hi  = d[15:0];
            8'h02: m_ctrl    = d[3:0];
            8'h03: m_ifg     = d[7:0];
            8'h04: m_mtu     = d[13:0];
            8'h05: m_scratch = d;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_mac_lo;
            8'h01:   return {16'd0, m_mac_hi};
            8'h02:   return {28'd0, m_ctrl};
            8'h03:   return {24'd0, m_ifg};
            8'h04:   return {18'd0, m_mtu};
            8'h05:   return m_scratch;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [73:0] model_outs();
        return {m_mac_hi, m_mac_lo, m_ctrl, m_ifg, m_mtu};
    endfunction

    function automatic logic [73:0] dut_outs();
        return {mac_addr, loopback, promisc, rx_en, tx_en, ifg, mtu};
    endfunction

    task automatic step();
        @(posedge clk_hifreq);
        #1;
    endtask

    // Issue one write strobe and follow it until busy drops (bounded).
    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            output int pulses, output int bcyc);
        wren = 1'b1; reg_addr = a; data_in = d;
        step();
        wren = 1'b0; reg_addr = 8'($urandom); data_in = $urandom;
        pulses = 0; bcyc = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            bcyc++;
            if (cfg_update) pulses++;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wren = 0; reg_addr = 0; data_in = 0; err_clr = 0; rd_addr = 0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        model_reset();
        n_checks++;
        if ({busy, cfg_update, err_addr, err_ovr, rd_data} !== 36'd0 || dut_outs() !== model_outs())
            $display("FAIL reset_state: busy=%0b upd=%0b ea=%0b eo=%0b rd=%h outs=%h expected outs=%h others 0",
                     busy, cfg_update, err_addr, err_ovr, rd_data, dut_outs(), model_outs());
        else n_pass++;
    endtask

    task automatic test_ifg_timing();
        logic [9:0] exp_v;
        wren = 1'b1; reg_addr = 8'h03; data_in = 32'h0000_0020;
        step();
        wren = 1'b0;
        for (int c = 1; c <= SETTLE_CYCLES + 3; c++) begin
            exp_v = {(c <= SETTLE_CYCLES + 2), (c == SETTLE_CYCLES + 2),
                     (c >= SETTLE_CYCLES + 2) ? 8'h20 : 8'd12};
            n_checks++;
            if ({busy, cfg_update, ifg} !== exp_v)
                $display("FAIL ifg_timing cycle %0d: {busy,upd,ifg}=%b expected %b", c, {busy, cfg_update, ifg}, exp_v);
            else n_pass++;
            step();
        end
        model_write(8'h03, 32'h20);
    endtask

    task automatic test_mac();
        int p, b;
        do_write(8'h00, 32'hAABB_CCDD, p, b);
        do_write(8'h01, 32'h1234_1122, p, b);
        model_write(8'h00, 32'hAABB_CCDD);
        model_write(8'h01, 32'h1234_1122);
        n_checks++;
        if (mac_addr !== 48'h1122_AABB_CCDD)
            $display("FAIL mac_addr: got %h expected %h", mac_addr, 48'h1122_AABB_CCDD);
        else n_pass++;
        rd_addr = 8'h01;
        step();
        n_checks++;
        if (rd_data !== 32'h0000_1122)
            $display("FAIL rd_mac_hi: got %h expected %h", rd_data, 32'h0000_1122);
        else n_pass++;
    endtask

    task automatic test_unmapped();
        int p, b;
        do_write(8'h07, 32'hFFFF_FFFF, p, b);
        n_checks++;
        if (b !== 1 || p !== 0 || err_addr !== 1'b1 || dut_outs() !== model_outs())
            $display("FAIL unmapped: busy_cycles=%0d pulses=%0d err_addr=%0b outs=%h expected 1/0/1 outs=%h",
                     b, p, err_addr, dut_outs(), model_outs());
        else n_pass++;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++;
        if (err_addr !== 1'b0)
            $display("FAIL err_addr_clear: got %0b expected 0", err_addr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        wren = 1'b1; reg_addr = 8'h05; data_in = 32'hCAFE_F00D;
        step();
        wren = 1'b0;
        step();
        wren = 1'b1; reg_addr = 8'h03; data_in = 32'h0000_0077;
        step();
        wren = 1'b0;
        for (int i = 0; i < 40 && busy; i++) begin
            if (cfg_update) pulses++;
            step();
        end
        model_write(8'h05, 32'hCAFE_F00D);
        n_checks++;
        if (err_ovr !== 1'b1 || pulses !== 1 || busy !== 1'b0 || dut_outs() !== model_outs())
            $display("FAIL overrun: err_ovr=%0b pulses=%0d busy=%0b outs=%h expected 1/1/0 outs=%h",
                     err_ovr, pulses, busy, dut_outs(), model_outs());
        else n_pass++;
        rd_addr = 8'h05;
        step();
        n_checks++;
        if (rd_data !== 32'hCAFE_F00D)
            $display("FAIL overrun_scratch: got %h expected %h", rd_data, 32'hCAFE_F00D);
        else n_pass++;
    endtask

    task automatic test_clr_vs_ovr();
        int p, b;
        bit seen;
        seen = 0;
        // err_ovr is still set from the previous scenario.
        wren = 1'b1; reg_addr = 8'h02; data_in = 32'h0000_0005;
        step();
        wren = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (cfg_update) seen = 1;
            else step();
        end
        model_write(8'h02, 32'h5);
        // Overrun in DONE coincides with a clear.
        wren = 1'b1; err_clr = 1'b1; reg_addr = 8'h03; data_in = 32'h0000_00EE;
        step();
        wren = 1'b0; err_clr = 1'b0;
        n_checks++;
        if (!seen || err_ovr !== 1'b1 || busy !== 1'b0)
            $display("FAIL clr_vs_ovr: done_seen=%0b err_ovr=%0b busy=%0b expected 1/1/0", seen, err_ovr, busy);
        else n_pass++;
        repeat (SETTLE_CYCLES + 3) step();
        n_checks++;
        if (dut_outs() !== model_outs())
            $display("FAIL dropped_in_done: outs=%h expected %h", dut_outs(), model_outs());
        else n_pass++;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++;
        if (err_ovr !== 1'b0)
            $display("FAIL err_ovr_clear: got %0b expected 0", err_ovr);
        else n_pass++;
        do_write(8'h06, 32'h0, p, b);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        wren = 1'b1; reg_addr = 8'h04; data_in = 32'h0000_0100;
        step();
        wren = 1'b0;
        step();
        step();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || cfg_update !== 1'b0)
            $display("FAIL reset_mid_busy: busy=%0b upd=%0b expected 0/0", busy, cfg_update);
        else n_pass++;
        step();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < SETTLE_CYCLES + 4; i++) begin
            step();
            if (cfg_update) pulses++;
        end
        n_checks++;
        if (mtu !== 14'd1518 || pulses !== 0 || dut_outs() !== model_outs())
            $display("FAIL reset_mid: mtu=%0d pulses=%0d expected 1518/0", mtu, pulses);
        else n_pass++;
    endtask

    task automatic test_random();
        int p, b, exp_b;
        logic [7:0]  a, ra;
        logic [31:0] d;
        for (int it = 0; it < 40; it++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            d = $urandom;
            do_write(a, d, p, b);
            exp_b = model_mapped(a) ? SETTLE_CYCLES + 2 : 1;
            if (model_mapped(a)) model_write(a, d);
            n_checks++;
            if (b !== exp_b || p !== int'(model_mapped(a)) || err_addr !== !model_mapped(a)
                || dut_outs() !== model_outs())
                $display("FAIL rand_write %0d addr=%h: busy_cycles=%0d/%0d pulses=%0d err_addr=%0b outs=%h expected outs=%h",
                         it, a, b, exp_b, p, err_addr, dut_outs(), model_outs());
            else n_pass++;
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            rd_addr = ra; err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            n_checks++;
            if (rd_data !== model_read(ra) || err_addr !== 1'b0)
                $display("FAIL rand_read addr=%h: got %h expected %h err_addr=%0b", ra, rd_data, model_read(ra), err_addr);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ifg_timing();
        test_mac();
        test_unmapped();
        test_back_to_back();
        test_clr_vs_ovr();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
